// File: rtl/fft_sched_pkg.sv
// fft_sched_pkg: shared constants and types for the FFT frame scheduler.
//   FFT_NUM / FRAME_LEN : log2 frame length and frame length in samples
//   NUM_CH / CH_W       : requesting channels and width of a channel ID
//   TAG_DEPTH           : frames that may be in flight inside the FFT core
//   IDLE_TIMEOUT        : idle cycles with real frames pending before a flush
//   sched_state_e       : one-hot scheduler states
//   tag_t               : per-frame tag {flush_bit, ch_id}
package fft_sched_pkg;

    localparam int unsigned FFT_NUM      = 6;
    localparam int unsigned NUM_CH       = 4;
    localparam int unsigned TAG_DEPTH    = 4;
    localparam int unsigned IDLE_TIMEOUT = 16;

    localparam int unsigned FRAME_LEN = 1 << FFT_NUM;
    localparam int unsigned CH_W      = $clog2(NUM_CH);
    localparam int unsigned IDLE_W    = $clog2(IDLE_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'b001,
        S_BURST = 3'b010,
        S_FLUSH = 3'b100
    } sched_state_e;

    typedef struct packed {
        logic            flush_bit;
        logic [CH_W-1:0] ch_id;
    } tag_t;

endpackage

// File: rtl/fft_frame_sched_if.sv
// fft_frame_sched_if: request/grant, FFT core and output-tag signals of the
// frame scheduler.
//   master : scheduler side (drives grant, core_*, out_*, busy, err_underflow)
//   slave  : environment side (drives req and core_dout_valid)
interface fft_frame_sched_if;
    import fft_sched_pkg::*;

    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] grant;
    logic              core_din_valid;
    logic              core_zero;
    logic              core_dout_valid;
    logic              out_valid;
    logic [CH_W-1:0]   out_ch;
    logic              out_sof;
    logic              out_eof;
    logic              busy;
    logic              err_underflow;

    modport master (
        input  req, core_dout_valid,
        output grant, core_din_valid, core_zero,
               out_valid, out_ch, out_sof, out_eof, busy, err_underflow
    );

    modport slave (
        output req, core_dout_valid,
        input  grant, core_din_valid, core_zero,
               out_valid, out_ch, out_sof, out_eof, busy, err_underflow
    );

endinterface

// File: rtl/fft_tag_fifo.sv
// fft_tag_fifo: synchronous FIFO of frame tags for frames inside the FFT core.
//   clk, rst     : clock, synchronous active-high reset
//   push, din    : write a tag (accepted when not full, or full with a pop)
//   pop          : drop the head tag (ignored when empty)
//   head         : tag at the read pointer (registered storage)
//   full, empty  : occupancy flags
//   real_pending : at least one non-flush tag is stored
module fft_tag_fifo
    import fft_sched_pkg::*;
#(
    parameter int unsigned DEPTH = TAG_DEPTH
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  tag_t din,
    input  logic pop,
    output tag_t head,
    output logic full,
    output logic empty,
    output logic real_pending
);

    localparam int unsigned AW = $clog2(DEPTH);

    tag_t         mem_q [DEPTH];
    tag_t         mem_d [DEPTH];
    logic [AW:0]  wr_q, wr_d;
    logic [AW:0]  rd_q, rd_d;
    logic [AW:0]  real_q, real_d;
    logic         pop_ok;
    logic         push_ok;

    always_comb begin
        empty        = (wr_q == rd_q);
        full         = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        head         = mem_q[rd_q[AW-1:0]];
        pop_ok       = pop && !empty;
        push_ok      = push && (!full || pop_ok);
        real_pending = (real_q != '0);

        mem_d = mem_q;
        if (push_ok) begin
            mem_d[wr_q[AW-1:0]] = din;
        end
        wr_d   = wr_q + (AW+1)'(push_ok);
        rd_d   = rd_q + (AW+1)'(pop_ok);
        real_d = real_q + (AW+1)'(push_ok && !din.flush_bit)
                        - (AW+1)'(pop_ok && !head.flush_bit);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q   <= '0;
            rd_q   <= '0;
            real_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            real_q <= real_d;
            mem_q  <= mem_d;
        end
    end

endmodule

// File: rtl/fft_frame_sched.sv
// fft_frame_sched: shares one FFT pipeline among NUM_CH channels, granting
// whole frames round-robin, tagging each frame in flight and injecting
// zero-data flush frames when traffic stops.
//   clk, rst : clock, synchronous active-high reset
//   bus      : master modport of fft_frame_sched_if
//              req in / grant out (one-hot, held for the burst)
//              core_din_valid, core_zero out; core_dout_valid in
//              out_valid, out_ch, out_sof, out_eof out (combinational)
//              busy, err_underflow (sticky) out
module fft_frame_sched
    import fft_sched_pkg::*;
(
    input logic               clk,
    input logic               rst,
    fft_frame_sched_if.master bus
);

    localparam logic [FFT_NUM-1:0] CNT_LAST = FFT_NUM'(FRAME_LEN - 1);
    localparam logic [IDLE_W-1:0]  IDLE_MAX = IDLE_W'(IDLE_TIMEOUT);

    sched_state_e        state_q, state_d;
    logic [FFT_NUM-1:0]  cnt_q, cnt_d;
    logic [FFT_NUM-1:0]  ocnt_q, ocnt_d;
    logic [NUM_CH-1:0]   grant_q, grant_d;
    logic [CH_W-1:0]     last_q, last_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [IDLE_W-1:0]   idle_q, idle_d;
    logic                err_q, err_d;

    logic                pick_valid;
    logic [CH_W-1:0]     pick_idx;
    logic [CH_W-1:0]     cand;

    logic                fifo_push, fifo_pop, pop_eff;
    logic                fifo_full, fifo_empty, real_pending;
    tag_t                push_tag, head;

    logic                eligible, decide, start_real, start_flush;

    fft_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tag_fifo (
        .clk          (clk),
        .rst          (rst),
        .push         (fifo_push),
        .din          (push_tag),
        .pop          (fifo_pop),
        .head         (head),
        .full         (fifo_full),
        .empty        (fifo_empty),
        .real_pending (real_pending)
    );

    // Round-robin pick: first requester after the last granted channel.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned i = 1; i <= NUM_CH; i++) begin
            cand = CH_W'((32'(last_q) + i) % NUM_CH);
            if (!pick_valid && bus.req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Tag push on the first cycle of every burst; pop on the last output beat.
    always_comb begin
        fifo_push          = (state_q != S_IDLE) && (cnt_q == '0);
        push_tag.flush_bit = (state_q == S_FLUSH);
        push_tag.ch_id     = (state_q == S_FLUSH) ? '0 : ch_q;
        fifo_pop           = bus.core_dout_valid && (ocnt_q == CNT_LAST);
        pop_eff            = fifo_pop && !fifo_empty;
    end

    // A slot freed by this cycle's pop already counts toward eligibility,
    // since the new burst's tag is only pushed a cycle later.
    always_comb begin
        eligible    = !fifo_full || pop_eff;
        decide      = (state_q == S_IDLE) || (cnt_q == CNT_LAST);
        start_real  = decide && pick_valid && eligible;
        start_flush = decide && !pick_valid && real_pending
                      && (idle_q == IDLE_MAX) && eligible;
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        ch_d    = ch_q;
        cnt_d   = (state_q == S_IDLE) ? '0 : cnt_q + 1'b1;

        if (decide) begin
            if (start_real) begin
                state_d = S_BURST;
                grant_d = NUM_CH'(1) << pick_idx;
                last_d  = pick_idx;
                ch_d    = pick_idx;
            end else if (start_flush) begin
                state_d = S_FLUSH;
                grant_d = '0;
            end else begin
                state_d = S_IDLE;
                grant_d = '0;
            end
            cnt_d = '0;
        end

        idle_d = idle_q;
        if (start_real || start_flush || !real_pending) begin
            idle_d = '0;
        end else if ((state_q == S_IDLE) && (idle_q != IDLE_MAX)) begin
            idle_d = idle_q + 1'b1;
        end

        ocnt_d = ocnt_q;
        if (bus.core_dout_valid && !fifo_empty) begin
            ocnt_d = ocnt_q + 1'b1;
        end

        err_d = err_q || (bus.core_dout_valid && fifo_empty);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ocnt_q  <= '0;
            grant_q <= '0;
            last_q  <= CH_W'(NUM_CH - 1);
            ch_q    <= '0;
            idle_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ocnt_q  <= ocnt_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            ch_q    <= ch_d;
            idle_q  <= idle_d;
            err_q   <= err_d;
        end
    end

    assign bus.grant          = grant_q;
    assign bus.core_din_valid = (state_q != S_IDLE);
    assign bus.core_zero      = (state_q == S_FLUSH);
    assign bus.out_valid      = bus.core_dout_valid && !fifo_empty && !head.flush_bit;
    assign bus.out_ch         = fifo_empty ? '0 : head.ch_id;
    assign bus.out_sof        = bus.out_valid && (ocnt_q == '0);
    assign bus.out_eof        = bus.out_valid && (ocnt_q == CNT_LAST);
    assign bus.busy           = !fifo_empty || (state_q != S_IDLE);
    assign bus.err_underflow  = err_q;

endmodule
